// File: rtl/cic_pkg.sv
// Shared CIC helpers: bit-growth arithmetic and stage/ratio limits used by both the
// interpolator and the decimator.
package cic_pkg;

    localparam int unsigned CIC_N_MIN = 1;
    localparam int unsigned CIC_N_MAX = 8;
    localparam int unsigned CIC_R_MIN = 2;
    localparam int unsigned CIC_M_MIN = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 31) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Minimum wrap-safe output width for an interpolating CIC chain
    function automatic int unsigned cic_out_width(input int unsigned iw,
                                                  input int unsigned n,
                                                  input int unsigned r,
                                                  input int unsigned m);
        return iw + n * clog2(r * m) - clog2(r);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single wrap-around accumulator stage of the CIC integrator section.
module cic_integrator #(
    parameter int unsigned OW = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          en_i,
    input  logic [OW-1:0] data_i,
    output logic [OW-1:0] acc_o
);

    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: low-rate comb chain, zero-stuffing upsampler and a
// full-rate integrator chain producing one output per clock.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int unsigned IW = 2,
    parameter int unsigned OW = 8,
    parameter int unsigned N  = 3,
    parameter int unsigned M  = 1,
    parameter int unsigned R  = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [IW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_req,
    output logic [OW-1:0] o_data,
    output logic          o_ready,
    output logic          o_underrun
);

    localparam int unsigned PW = (clog2(R) < 1) ? 1 : clog2(R);
    localparam bit PARAMS_OK = (N >= CIC_N_MIN) && (N <= CIC_N_MAX) &&
                               (R >= CIC_R_MIN) && (M >= CIC_M_MIN) &&
                               (OW >= cic_out_width(IW, N, R, M));

    logic [PW-1:0]             phase_q;
    logic [PW-1:0]             phase_d;
    logic                      strobe_c;
    logic [N:0][OW-1:0]        comb_c;
    logic [N-1:0][M-1:0][OW-1:0] dl_q;
    logic [OW-1:0]             comb_q;
    logic                      stuff_q;
    logic                      underrun_q;
    logic                      underrun_d;
    logic                      ready_q;
    logic [OW-1:0]             data_q;
    logic [N:0][OW-1:0]        integ_c;

    assign strobe_c = (phase_q == '0);

    // Phase wrap, sticky underrun and the comb chain evaluated at the input rate
    always_comb begin
        phase_d    = (phase_q == PW'(R - 1)) ? '0 : phase_q + PW'(1);
        underrun_d = underrun_q | (strobe_c & ~i_ready);
        comb_c[0]  = i_ready ? OW'(signed'(i_data)) : '0;
        for (int k = 0; k < N; k++) begin
            comb_c[k+1] = comb_c[k] - dl_q[k][M-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q    <= PW'(R - 1);
            dl_q       <= '0;
            comb_q     <= '0;
            stuff_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            stuff_q    <= strobe_c;
            underrun_q <= underrun_d;
            ready_q    <= 1'b1;
            data_q     <= integ_c[N];
            if (strobe_c) begin
                comb_q <= comb_c[N];
                for (int k = 0; k < N; k++) begin
                    for (int j = M - 1; j > 0; j--) begin
                        dl_q[k][j] <= dl_q[k][j-1];
                    end
                    dl_q[k][0] <= comb_c[k];
                end
            end
        end
    end

    // Zero-stuffed comb output feeds the first integrator for one clock in R
    assign integ_c[0] = stuff_q ? comb_q : '0;

    for (genvar k = 0; k < N; k++) begin : g_integ
        cic_integrator #(
            .OW(OW)
        ) u_integ (
            .clk_i  (i_clk),
            .reset_i(i_reset),
            .en_i   (1'b1),
            .data_i (integ_c[k]),
            .acc_o  (integ_c[k+1])
        );
    end

    a_params_ok : assert property (@(posedge i_clk) PARAMS_OK);

    assign o_req      = (phase_q == PW'(R - 1)) && !i_reset;
    assign o_data     = data_q;
    assign o_ready    = ready_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed checks of the CIC interpolator in three configurations sharing one clock.
module tb_cic_interpolator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N=3, R=4, M=1, IW=2
    logic [1:0] d3;
    logic       r3, req3, ordy3, und3;
    logic [7:0] out3;
    // N=2, R=2, M=1, IW=2
    logic [1:0] d2;
    logic       r2, req2, ordy2, und2;
    logic [7:0] out2;
    // N=1, R=4, M=1, IW=3
    logic [2:0] d1;
    logic       r1, req1, ordy1, und1;
    logic [7:0] out1;

    int checks = 0;
    int errors = 0;

    cic_interpolator #(.IW(2), .OW(8), .N(3), .M(1), .R(4)) u_main (
        .i_clk(clk), .i_reset(rst), .i_data(d3), .i_ready(r3),
        .o_req(req3), .o_data(out3), .o_ready(ordy3), .o_underrun(und3)
    );

    cic_interpolator #(.IW(2), .OW(8), .N(2), .M(1), .R(2)) u_n2 (
        .i_clk(clk), .i_reset(rst), .i_data(d2), .i_ready(r2),
        .o_req(req2), .o_data(out2), .o_ready(ordy2), .o_underrun(und2)
    );

    cic_interpolator #(.IW(3), .OW(8), .N(1), .M(1), .R(4)) u_n1 (
        .i_clk(clk), .i_reset(rst), .i_data(d1), .i_ready(r1),
        .o_req(req1), .o_data(out1), .o_ready(ordy1), .o_underrun(und1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d3 = 2'd0; r3 = 1'b1;
        d2 = 2'd0; r2 = 1'b1;
        d1 = 3'd0; r1 = 1'b1;
    endtask

    // After this returns the bench sits in cycle 0: phase R-1, reset released
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        r3 = 1'b0;
        d3 = 2'd1;
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        idle_inputs();
        tick();
        checks++; if (ordy3 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ordy3); end
        checks++; if (req3 !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", req3); end
        checks++; if (out3 !== 8'd0) begin errors++; $display("FAIL rst_data got %0d exp 0", out3); end
        checks++; if (und3 !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", und3); end
        checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL rst_req_n2 got %b exp 0", req2); end
        rst = 1'b0;
        #1;
        checks++; if (req3 !== 1'b1) begin errors++; $display("FAIL rel_req got %b exp 1", req3); end
        checks++; if (ordy3 !== 1'b0) begin errors++; $display("FAIL rel_ready got %b exp 0", ordy3); end
        tick();
        checks++; if (ordy3 !== 1'b1) begin errors++; $display("FAIL post_ready got %b exp 1", ordy3); end
        checks++; if (ordy1 !== 1'b1) begin errors++; $display("FAIL post_ready_n1 got %b exp 1", ordy1); end
        checks++; if (req3 !== 1'b0) begin errors++; $display("FAIL post_req got %b exp 0", req3); end
    endtask

    // N=2,R=2 impulse: taps 1,2,1 starting three edges after the strobe edge
    task automatic test_impulse_n2();
        int h2[3] = '{1, 2, 1};
        do_reset();
        for (int c = 0; c < 14; c++) begin
            int e;
            e = (c >= 5 && c < 8) ? h2[c-5] : 0;
            checks++;
            if (out2 !== 8'(e)) begin
                errors++; $display("FAIL imp_n2 cyc %0d got %0d exp %0d", c, $signed(out2), e);
            end
            d2 = (c == 1) ? 2'd1 : 2'd0;
            r2 = 1'b1;
            tick();
        end
    endtask

    task automatic test_dc_gain();
        do_reset();
        for (int c = 0; c < 28; c++) begin
            int e;
            e = (c < 6) ? 0 : ((c == 6) ? 1 : 16);
            if (c <= 6 || c >= 20) begin
                checks++;
                if (out3 !== 8'(e)) begin
                    errors++; $display("FAIL dc_pos cyc %0d got %0d exp %0d", c, $signed(out3), e);
                end
            end
            d3 = 2'd1; r3 = 1'b1;
            tick();
        end
        d3 = 2'b10;
        for (int c = 0; c < 4000; c++) tick();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (out3 !== 8'hE0) begin
                errors++; $display("FAIL dc_neg cyc %0d got %0d exp -32", c, $signed(out3));
            end
            tick();
        end
    endtask

    task automatic test_zoh_n1();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            int e;
            e = (c < 4) ? 0 : 3;
            checks++;
            if (out1 !== 8'(e)) begin
                errors++; $display("FAIL zoh_n1 cyc %0d got %0d exp %0d", c, $signed(out1), e);
            end
            d1 = 3'd3; r1 = 1'b1;
            tick();
        end
    endtask

    // Impulse at slot 1, then slot 5 starved with nonzero data on i_data
    task automatic test_underrun();
        int h3[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
        do_reset();
        for (int c = 0; c < 20; c++) begin
            int e;
            e = (c >= 6 && c < 16) ? h3[c-6] : 0;
            checks++;
            if (out3 !== 8'(e)) begin
                errors++; $display("FAIL urun_data cyc %0d got %0d exp %0d", c, $signed(out3), e);
            end
            checks++;
            if (und3 !== (c >= 6)) begin
                errors++; $display("FAIL urun_flag cyc %0d got %b exp %b", c, und3, (c >= 6));
            end
            checks++;
            if (req3 !== (c % 4 == 0)) begin
                errors++; $display("FAIL urun_req cyc %0d got %b exp %b", c, req3, (c % 4 == 0));
            end
            r3 = (c != 5);
            d3 = (c == 1 || c == 5) ? 2'd1 : 2'd0;
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        int h2[3] = '{1, 2, 1};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            r3 = (c != 5); d3 = 2'd1;
            r2 = 1'b1;     d2 = 2'd1;
            tick();
        end
        checks++; if (und3 !== 1'b1) begin errors++; $display("FAIL mid_pre_urun got %b exp 1", und3); end
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out3 !== 8'd0) begin errors++; $display("FAIL mid_data got %0d exp 0", out3); end
        checks++; if (und3 !== 1'b0) begin errors++; $display("FAIL mid_urun got %b exp 0", und3); end
        checks++; if (req3 !== 1'b1) begin errors++; $display("FAIL mid_req got %b exp 1", req3); end
        checks++; if (req2 !== 1'b1) begin errors++; $display("FAIL mid_req_n2 got %b exp 1", req2); end
        for (int c = 0; c < 14; c++) begin
            int e;
            e = (c >= 5 && c < 8) ? h2[c-5] : 0;
            checks++;
            if (out2 !== 8'(e)) begin
                errors++; $display("FAIL mid_restart cyc %0d got %0d exp %0d", c, $signed(out2), e);
            end
            checks++;
            if (out3 !== 8'd0) begin
                errors++; $display("FAIL mid_main_zero cyc %0d got %0d exp 0", c, $signed(out3));
            end
            d2 = (c == 1) ? 2'd1 : 2'd0;
            r2 = 1'b1;
            tick();
        end
    endtask

    // Ready toggles with nonzero data off phase 0; only the slot-1 impulse counts
    task automatic test_ignored_ready();
        int h3[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
        do_reset();
        for (int c = 0; c < 20; c++) begin
            int e;
            e = (c >= 6 && c < 16) ? h3[c-6] : 0;
            checks++;
            if (out3 !== 8'(e)) begin
                errors++; $display("FAIL ign_data cyc %0d got %0d exp %0d", c, $signed(out3), e);
            end
            checks++;
            if (und3 !== 1'b0) begin
                errors++; $display("FAIL ign_urun cyc %0d got %b exp 0", c, und3);
            end
            if (c % 4 == 1) begin
                r3 = 1'b1;
                d3 = (c == 1) ? 2'd1 : 2'd0;
            end else begin
                r3 = (c % 2 == 0);
                d3 = (c % 3 == 0) ? 2'b10 : 2'b01;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_impulse_n2();
        test_dc_gain();
        test_zoh_n1();
        test_underrun();
        test_reset_midstream();
        test_ignored_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
